// File: rtl/pmci_vdm_ingr_pkg.sv
// Shared definitions for the PMCI VDM ingress AVMM filter: FSM state codes,
// default constants and the request-accept rule.
package pmci_vdm_ingr_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_WR      = 3'd1;
    localparam state_t ST_RD      = 3'd2;
    localparam state_t ST_ACK     = 3'd3;
    localparam state_t ST_RD_WAIT = 3'd4;
    localparam state_t ST_RD_ERR  = 3'd5;

    localparam logic [31:0] DEF_PASS_ADDR  = 32'h0000_81D0;
    localparam logic [31:0] DEF_ERR_RDDATA = 32'hDEAD_BEEF;

    // Only full-word accesses to the VDM window (any bit at or above csr_awidth set)
    // or to the single pass-through CSR address reach the buffer.
    function automatic logic accept(input logic [31:0] addr,
                                    input logic [3:0]  byteen,
                                    input int unsigned csr_awidth,
                                    input logic [31:0] pass_addr);
        logic in_window;
        in_window = ((addr >> csr_awidth) != 32'd0);
        return (byteen == 4'hF) && (in_window || (addr == pass_addr));
    endfunction

endpackage

// File: rtl/pmci_sat_cnt.sv
// Saturating up-counter with a clear that wins over a same-cycle increment.
module pmci_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count up, hold at all-ones; clear and reset dominate.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pmci_vdm_ingr_avmm_filter.sv
// Registered filter between the SPI-slave bridge AVMM master and the MCTP VDM
// buffer ingress slave. Forwards accepted full-word accesses, completes all
// others locally, bounds the single outstanding read with a timeout.
module pmci_vdm_ingr_avmm_filter
    import pmci_vdm_ingr_pkg::*;
#(
    parameter int unsigned INGR_SLV_ADDR_WIDTH = 16,
    parameter int unsigned INGR_SLV_CSR_AWIDTH = 16,
    parameter logic [31:0] PASS_ADDR           = DEF_PASS_ADDR,
    parameter int unsigned RD_TIMEOUT          = 1023,
    parameter logic [31:0] ERR_RDDATA          = DEF_ERR_RDDATA
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    // Upstream (SPI-slave bridge master)
    input  logic [31:0]                    i_up_addr,
    input  logic                           i_up_write,
    input  logic                           i_up_read,
    input  logic [3:0]                     i_up_byteen,
    input  logic [31:0]                    i_up_wrdata,
    output logic [31:0]                    o_up_rddata,
    output logic                           o_up_rdvld,
    output logic                           o_up_waitreq,
    // Downstream (VDM buffer ingress slave)
    output logic [INGR_SLV_ADDR_WIDTH-1:0] o_dn_addr,
    output logic                           o_dn_write,
    output logic                           o_dn_read,
    output logic [31:0]                    o_dn_wrdata,
    input  logic [31:0]                    i_dn_rddata,
    input  logic                           i_dn_rddvld,
    input  logic                           i_dn_waitreq,
    // Debug
    input  logic                           i_dbg_clr,
    output logic [31:0]                    o_dbg_sts
);

    localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);

    state_t                         r_state;
    state_t                         r_after_ack;
    logic [INGR_SLV_ADDR_WIDTH-1:0] r_dn_addr;
    logic [31:0]                    r_wrdata;
    logic                           r_rdvld;
    logic [31:0]                    r_rddata;
    logic [TW-1:0]                  r_rd_cnt;
    logic                           r_sticky;

    logic        w_accept;
    logic        w_idle;
    logic        w_drop_wr;
    logic        w_drop_rd;
    logic        w_timeout;
    logic [15:0] w_drop_wr_cnt;
    logic [14:0] w_drop_rd_cnt;

    assign w_accept  = accept(i_up_addr, i_up_byteen, INGR_SLV_CSR_AWIDTH, PASS_ADDR);
    assign w_idle    = (r_state == ST_IDLE);
    // Write wins when both strobes are high, so a read only counts when write is low.
    assign w_drop_wr = w_idle && i_up_write && !w_accept;
    assign w_drop_rd = w_idle && !i_up_write && i_up_read && !w_accept;
    assign w_timeout = (r_state == ST_RD_WAIT) && !i_dn_rddvld && (r_rd_cnt == TMO_LAST);

    // Main transaction FSM with latched request fields and registered read return.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_after_ack <= ST_IDLE;
            r_dn_addr   <= '0;
            r_wrdata    <= '0;
            r_rdvld     <= 1'b0;
            r_rddata    <= '0;
            r_rd_cnt    <= '0;
        end else begin
            r_rdvld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_up_write || i_up_read) begin
                        r_dn_addr <= i_up_addr[INGR_SLV_ADDR_WIDTH+1:2];
                        r_wrdata  <= i_up_wrdata;
                        if (i_up_write) begin
                            r_after_ack <= ST_IDLE;
                            r_state     <= w_accept ? ST_WR : ST_ACK;
                        end else begin
                            r_after_ack <= w_accept ? ST_RD_WAIT : ST_RD_ERR;
                            r_state     <= w_accept ? ST_RD : ST_ACK;
                        end
                    end
                end
                ST_WR: begin
                    if (!i_dn_waitreq) begin
                        r_state <= ST_ACK;
                    end
                end
                ST_RD: begin
                    if (!i_dn_waitreq) begin
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_state  <= r_after_ack;
                    r_rd_cnt <= '0;
                end
                ST_RD_WAIT: begin
                    if (i_dn_rddvld) begin
                        r_rdvld  <= 1'b1;
                        r_rddata <= i_dn_rddata;
                        r_state  <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_rdvld  <= 1'b1;
                        r_rddata <= ERR_RDDATA;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + TW'(1);
                    end
                end
                ST_RD_ERR: begin
                    r_rdvld  <= 1'b1;
                    r_rddata <= ERR_RDDATA;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky read-timeout flag; clear beats a same-cycle timeout.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_dbg_clr) begin
            r_sticky <= 1'b0;
        end else if (w_timeout) begin
            r_sticky <= 1'b1;
        end
    end

    pmci_sat_cnt #(
        .W (16)
    ) u_drop_wr_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (i_dbg_clr),
        .i_inc   (w_drop_wr),
        .o_cnt   (w_drop_wr_cnt)
    );

    pmci_sat_cnt #(
        .W (15)
    ) u_drop_rd_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (i_dbg_clr),
        .i_inc   (w_drop_rd),
        .o_cnt   (w_drop_rd_cnt)
    );

    assign o_up_waitreq = (r_state != ST_ACK);
    assign o_up_rdvld   = r_rdvld;
    assign o_up_rddata  = r_rddata;
    assign o_dn_write   = (r_state == ST_WR);
    assign o_dn_read    = (r_state == ST_RD);
    assign o_dn_addr    = r_dn_addr;
    assign o_dn_wrdata  = r_wrdata;
    assign o_dbg_sts    = {r_sticky, w_drop_rd_cnt, w_drop_wr_cnt};

endmodule

// File: tb/tb_pmci_vdm_ingr_avmm_filter.sv
// Self-checking bench for pmci_vdm_ingr_avmm_filter: directed scenarios plus
// randomized transactions checked against a transaction-level reference model.
module tb_pmci_vdm_ingr_avmm_filter;

    localparam int unsigned T   = 12;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] up_addr;
    logic        up_write;
    logic        up_read;
    logic [3:0]  up_byteen;
    logic [31:0] up_wrdata;
    logic [31:0] up_rddata;
    logic        up_rdvld;
    logic        up_waitreq;
    logic [15:0] dn_addr;
    logic        dn_write;
    logic        dn_read;
    logic [31:0] dn_wrdata;
    logic [31:0] dn_rddata;
    logic        dn_rddvld;
    logic        dn_waitreq;
    logic        dbg_clr;
    logic [31:0] dbg_sts;

    always #5 clk = ~clk;

    pmci_vdm_ingr_avmm_filter #(
        .RD_TIMEOUT (T)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_up_addr    (up_addr),
        .i_up_write   (up_write),
        .i_up_read    (up_read),
        .i_up_byteen  (up_byteen),
        .i_up_wrdata  (up_wrdata),
        .o_up_rddata  (up_rddata),
        .o_up_rdvld   (up_rdvld),
        .o_up_waitreq (up_waitreq),
        .o_dn_addr    (dn_addr),
        .o_dn_write   (dn_write),
        .o_dn_read    (dn_read),
        .o_dn_wrdata  (dn_wrdata),
        .i_dn_rddata  (dn_rddata),
        .i_dn_rddvld  (dn_rddvld),
        .i_dn_waitreq (dn_waitreq),
        .i_dbg_clr    (dbg_clr),
        .o_dbg_sts    (dbg_sts)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int   m_drop_wr = 0;
    int   m_drop_rd = 0;
    logic m_sticky  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_accept(input logic [31:0] addr, input logic [3:0] be);
        return (be == 4'hF) && ((addr >= 32'h0001_0000) || (addr == 32'h0000_81D0));
    endfunction

    function automatic logic [31:0] model_sts();
        logic [14:0] rd;
        logic [15:0] wr;
        rd = (m_drop_rd > 32767) ? 15'h7FFF : 15'(m_drop_rd);
        wr = (m_drop_wr > 65535) ? 16'hFFFF : 16'(m_drop_wr);
        return {m_sticky, rd, wr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One upstream transaction; the bench also plays the downstream buffer.
    // dn_wait: stall cycles on the downstream command; reply_dly: cycles after
    // the read enters its wait phase before the buffer answers.
    task automatic xact(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, input int dn_wait,
                        input logic reply, input int reply_dly, input logic [31:0] rdat,
                        input logic clr_at_req);
        logic        fwd, is_wr, is_rd, got_reply;
        int          cyc, ack_cyc, ack_n, dn_first, dn_wr_n, dn_rd_n, rdvld_n, rdvld_cyc;
        int          exp_ack, exp_rdvld_cyc, stop;
        logic [31:0] rdvld_data, first_dn_addr, first_dn_wd, exp_rdata;

        is_wr = wr;
        is_rd = rd && !wr;
        fwd   = model_accept(addr, be);

        if (clr_at_req) begin
            m_drop_wr = 0;
            m_drop_rd = 0;
            m_sticky  = 1'b0;
        end else begin
            if (is_wr && !fwd) m_drop_wr++;
            if (is_rd && !fwd) m_drop_rd++;
        end
        got_reply     = reply && (reply_dly < int'(T));
        exp_ack       = fwd ? dn_wait + 2 : 1;
        exp_rdata     = (is_rd && fwd && got_reply) ? rdat : ERR;
        exp_rdvld_cyc = (is_rd && fwd) ? (got_reply ? exp_ack + reply_dly + 2 : exp_ack + int'(T) + 1)
                                       : exp_ack + 2;
        if (is_rd && fwd && !got_reply) m_sticky = 1'b1;

        up_addr    = addr;
        up_byteen  = be;
        up_wrdata  = wd;
        up_write   = wr;
        up_read    = rd;
        dbg_clr    = clr_at_req;
        dn_waitreq = 1'b0;
        dn_rddvld  = 1'b0;
        dn_rddata  = rdat;

        cyc = 0; ack_cyc = -1; ack_n = 0; dn_first = -1; dn_wr_n = 0; dn_rd_n = 0;
        rdvld_n = 0; rdvld_cyc = -1; rdvld_data = 'x; first_dn_addr = 'x; first_dn_wd = 'x;
        stop = 40;
        while (cyc < stop) begin
            tick();
            cyc++;
            dbg_clr   = 1'b0;
            dn_rddvld = 1'b0;
            if (dn_write || dn_read) begin
                if (dn_first < 0) begin
                    dn_first      = cyc;
                    first_dn_addr = 32'(dn_addr);
                    first_dn_wd   = dn_wrdata;
                end
                if (dn_write) dn_wr_n++;
                if (dn_read)  dn_rd_n++;
                dn_waitreq = ((dn_wr_n + dn_rd_n) <= dn_wait);
            end else begin
                dn_waitreq = 1'b0;
            end
            if (!up_waitreq) begin
                ack_n++;
                if (ack_cyc < 0) begin
                    ack_cyc  = cyc;
                    stop     = cyc + ((is_rd && fwd) ? int'(T) + 6 : 5);
                    up_write = 1'b0;
                    up_read  = 1'b0;
                end
            end
            if (up_rdvld) begin
                rdvld_n++;
                rdvld_cyc  = cyc;
                rdvld_data = up_rddata;
            end
            if (reply && ack_cyc >= 0 && cyc == ack_cyc + 1 + reply_dly) dn_rddvld = 1'b1;
        end
        up_write  = 1'b0;
        up_read   = 1'b0;
        dn_rddvld = 1'b0;

        check("ack_cycle",  32'(ack_cyc), 32'(exp_ack));
        check("ack_count",  32'(ack_n),   32'd1);
        check("dn_wr_cyc",  32'(dn_wr_n), (is_wr && fwd) ? 32'(dn_wait + 1) : 32'd0);
        check("dn_rd_cyc",  32'(dn_rd_n), (is_rd && fwd) ? 32'(dn_wait + 1) : 32'd0);
        if (fwd) begin
            check("dn_first", 32'(dn_first), 32'd1);
            check("dn_addr",  first_dn_addr, (addr >> 2) & 32'h0000_FFFF);
            if (is_wr) check("dn_wrdata", first_dn_wd, wd);
        end
        check("rdvld_cnt", 32'(rdvld_n), is_rd ? 32'd1 : 32'd0);
        if (is_rd) begin
            check("rdvld_data", rdvld_data, exp_rdata);
            check("rdvld_cycle", 32'(rdvld_cyc), 32'(exp_rdvld_cyc));
        end
        check("dbg_sts", dbg_sts, model_sts());
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  b;
        int          k;

        reset = 1'b1; up_addr = '0; up_write = 1'b0; up_read = 1'b0; up_byteen = '0;
        up_wrdata = '0; dn_rddata = '0; dn_rddvld = 1'b0; dn_waitreq = 1'b0; dbg_clr = 1'b0;
        repeat (3) tick();
        check("rst_waitreq", 32'(up_waitreq), 32'd1);
        check("rst_dn_wr",   32'(dn_write),   32'd0);
        check("rst_dn_rd",   32'(dn_read),    32'd0);
        check("rst_rdvld",   32'(up_rdvld),   32'd0);
        check("rst_rddata",  up_rddata,       32'd0);
        check("rst_dn_addr", 32'(dn_addr),    32'd0);
        check("rst_sts",     dbg_sts,         32'd0);
        reset = 1'b0;
        tick();

        // Forwarded write, zero-wait buffer
        xact(1'b1, 1'b0, 32'h0001_0010, 4'hF, 32'hCAFE_0001, 0, 1'b0, 0, '0, 1'b0);
        // Pass-address read with 3 stall cycles and a reply
        xact(1'b0, 1'b1, 32'h0000_81D0, 4'hF, '0, 3, 1'b1, 2, 32'h1234_5678, 1'b0);
        // CSR-region write and read are completed locally
        xact(1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h1111_2222, 0, 1'b0, 0, '0, 1'b0);
        xact(1'b0, 1'b1, 32'h0000_1004, 4'hF, '0, 0, 1'b0, 0, '0, 1'b0);
        check("sts_wr_cnt", dbg_sts & 32'h0000_FFFF, 32'd1);
        check("sts_rd_cnt", (dbg_sts >> 16) & 32'h0000_7FFF, 32'd1);
        // Timeout with a late reply that must be ignored
        xact(1'b0, 1'b1, 32'h0003_0000, 4'hF, '0, 0, 1'b1, T + 2, 32'h5555_AAAA, 1'b0);
        check("sts_sticky", dbg_sts >> 31, 32'd1);
        // Reply on the last cycle before timeout still wins
        xact(1'b0, 1'b1, 32'h0003_0004, 4'hF, '0, 1, 1'b1, T - 1, 32'h0BAD_F00D, 1'b0);
        // Partial byte enables dropped; write beats simultaneous read
        xact(1'b1, 1'b0, 32'h0002_0000, 4'h3, 32'h0000_00FF, 0, 1'b0, 0, '0, 1'b0);
        xact(1'b1, 1'b1, 32'h0004_0040, 4'hF, 32'h7777_8888, 1, 1'b0, 0, '0, 1'b0);
        xact(1'b1, 1'b1, 32'h0000_0040, 4'hF, 32'h7777_8888, 0, 1'b0, 0, '0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(0, 3));
            if (k == 0)      a = $urandom_range(32'hFFFF_FFFF, 32'h0001_0000);
            else if (k == 1) a = 32'h0000_81D0;
            else             a = $urandom_range(32'h0000_FFFF, 0);
            b = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            k = int'($urandom_range(0, 2));
            xact(k != 1, k != 0, a, b, $urandom, int'($urandom_range(0, 3)),
                 $urandom_range(0, 4) != 0, int'($urandom_range(0, 5)), $urandom, 1'b0);
        end

        // Reset while a read is stalled downstream
        up_addr = 32'h0005_0000; up_byteen = 4'hF; up_read = 1'b1; dn_waitreq = 1'b1;
        tick();
        up_read = 1'b0;
        tick();
        check("rd_stalled", 32'(dn_read), 32'd1);
        reset = 1'b1;
        tick();
        check("rst_mid_dn_rd",   32'(dn_read),    32'd0);
        check("rst_mid_waitreq", 32'(up_waitreq), 32'd1);
        check("rst_mid_sts",     dbg_sts,         32'd0);
        reset = 1'b0; dn_waitreq = 1'b0;
        m_drop_wr = 0; m_drop_rd = 0; m_sticky = 1'b0;
        tick();

        // Build up statistics, then clear them
        xact(1'b1, 1'b0, 32'h0000_0100, 4'hF, '0, 0, 1'b0, 0, '0, 1'b0);
        xact(1'b0, 1'b1, 32'h0000_0104, 4'h1, '0, 0, 1'b0, 0, '0, 1'b0);
        xact(1'b0, 1'b1, 32'h0006_0000, 4'hF, '0, 0, 1'b0, 0, '0, 1'b0);
        dbg_clr = 1'b1;
        tick();
        dbg_clr = 1'b0;
        m_drop_wr = 0; m_drop_rd = 0; m_sticky = 1'b0;
        check("clr_sts", dbg_sts, 32'd0);
        // Clear in the same cycle as a drop increment: clear wins
        xact(1'b1, 1'b0, 32'h0000_0200, 4'hF, '0, 0, 1'b0, 0, '0, 1'b0);
        xact(1'b1, 1'b0, 32'h0000_0204, 4'hF, '0, 0, 1'b0, 0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
